stbus_rx_deframer: RTL and testbench

//  Receive-side front end for the DT serial TDM link. Samples the data_from_dt line

---
 rtl/stbus_rx_deframer.sv | 164 ++++++++++++++++
 tb/tb_stbus_rx_deframer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stbus_rx_deframer.sv
// rtl/stbus_rx_deframer.sv - DT serial TDM receive deframer: c4/f0 oversampling, byte assembly, frame lock
module stbus_rx_deframer #(
    parameter int CHANNELS    = 32,
    parameter int BITS_PER_CH = 8,
    parameter int BIT_DIV     = 2,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic            clk50,
    input  logic            reset_in_rg,
    input  logic            c4,
    input  logic            f0,
    input  logic            data_from_dt,
    input  logic            enable,
    output logic [7:0]      byte_data,
    output logic [CH_W-1:0] byte_channel,
    output logic            byte_valid,
    output logic            frame_start,
    output logic            locked,
    output logic            frame_err,
    output logic [15:0]     frame_count
);
    localparam int PH_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = $clog2(BITS_PER_CH);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_CH - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic {HUNT, RUN} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] c4_sync, f0_sync, data_sync;
    logic c4_prev, c4_rise, f0_r, data_r;

    logic [PH_W-1:0]        ph;
    logic [BIT_W-1:0]       bit_cnt;
    logic [CH_W-1:0]        ch;
    logic                   frame_full;
    logic [BITS_PER_CH-1:0] shift_reg, shift_nxt, byte_nxt;

    logic ev_start, ev_data, ev_aligned, ev_early, ev_miss;
    logic ph_last, bit_last, ch_last;

    // f0 and data are delayed alongside the edge register so all three stay aligned.
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            c4_sync   <= '0;
            f0_sync   <= '0;
            data_sync <= '0;
            c4_prev   <= 1'b0;
            c4_rise   <= 1'b0;
            f0_r      <= 1'b0;
            data_r    <= 1'b0;
        end else begin
            c4_sync   <= {c4_sync[SYNC_STAGES-2:0], c4};
            f0_sync   <= {f0_sync[SYNC_STAGES-2:0], f0};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_from_dt};
            c4_prev   <= c4_sync[SYNC_STAGES-1];
            c4_rise   <= c4_sync[SYNC_STAGES-1] & ~c4_prev;
            f0_r      <= f0_sync[SYNC_STAGES-1];
            data_r    <= data_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk50) begin
        if (reset_in_rg) state <= HUNT;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ev_start   = 1'b0;
        ev_data    = 1'b0;
        ev_aligned = 1'b0;
        ev_early   = 1'b0;
        ev_miss    = 1'b0;
        if (!enable) begin
            state_nxt = HUNT;
        end else if (c4_rise) begin
            case (state)
                HUNT: begin
                    if (!f0_r) begin
                        state_nxt = RUN;
                        ev_start  = 1'b1;
                    end
                end
                RUN: begin
                    if (!f0_r) begin
                        if (frame_full) ev_aligned = 1'b1;
                        else            ev_early   = 1'b1;
                    end else if (frame_full) begin
                        ev_miss   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        ev_data = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        ph_last   = (ph == PH_LAST);
        bit_last  = (bit_cnt == BIT_LAST);
        ch_last   = (ch == CH_LAST);
        shift_nxt = {shift_reg[BITS_PER_CH-2:0], data_r};
        byte_nxt  = (ph == '0) ? shift_nxt : shift_reg;
    end

    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            ph           <= '0;
            bit_cnt      <= '0;
            ch           <= '0;
            frame_full   <= 1'b0;
            shift_reg    <= '0;
            byte_data    <= '0;
            byte_channel <= '0;
            byte_valid   <= 1'b0;
            frame_start  <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
            frame_count  <= '0;
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            if (!enable) locked <= 1'b0;

            if (ev_start || ev_aligned || ev_early) begin
                ph         <= '0;
                bit_cnt    <= '0;
                ch         <= '0;
                frame_full <= 1'b0;
                shift_reg  <= '0;
            end
            if (ev_aligned) begin
                frame_start <= 1'b1;
                frame_count <= frame_count + 16'd1;
                locked      <= 1'b1;
            end
            if (ev_early || ev_miss) begin
                frame_err <= 1'b1;
                locked    <= 1'b0;
            end

            if (ev_data) begin
                if (ph == '0) shift_reg <= shift_nxt;
                ph <= ph_last ? '0 : ph + 1'b1;
                if (ph_last) begin
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                    if (bit_last) begin
                        byte_valid   <= 1'b1;
                        byte_data    <= byte_nxt;
                        byte_channel <= ch;
                        ch           <= ch_last ? '0 : ch + 1'b1;
                        if (ch_last) frame_full <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_stbus_rx_deframer.sv
// tb/tb_stbus_rx_deframer.sv - directed scoreboard bench for stbus_rx_deframer (2 channels)
module tb_stbus_rx_deframer;
    localparam int CHANNELS    = 2;
    localparam int BIT_DIV     = 2;
    localparam int SYNC_STAGES = 2;

    logic        clk50 = 1'b0;
    logic        reset_in_rg, c4, f0, data_from_dt, enable;
    logic [7:0]  byte_data;
    logic [0:0]  byte_channel;
    logic        byte_valid, frame_start, locked, frame_err;
    logic [15:0] frame_count;

    stbus_rx_deframer #(
        .CHANNELS(CHANNELS), .BITS_PER_CH(8), .BIT_DIV(BIT_DIV), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk50(clk50), .reset_in_rg(reset_in_rg), .c4(c4), .f0(f0),
        .data_from_dt(data_from_dt), .enable(enable), .byte_data(byte_data),
        .byte_channel(byte_channel), .byte_valid(byte_valid), .frame_start(frame_start),
        .locked(locked), .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int exp_q[$];
    int last_rise = 0, prev_rise = 0;
    int n_bv = 0, n_fs = 0, n_fe = 0;
    int mon_e, rise_ref;
    logic bv_d = 1'b0, fs_d = 1'b0, fe_d = 1'b0;
    bit jitter_on = 1'b0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every byte strobe must match the oldest expected (channel, byte).
    always @(negedge clk50) begin
        if (byte_valid) begin
            n_bv++;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte_valid", byte_data, -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("byte_data", byte_data, mon_e & 8'hFF);
                chk("byte_channel", byte_channel, (mon_e >> 8) & 1);
                rise_ref = (last_rise == cyc) ? prev_rise : last_rise;
                chk("bv_latency", cyc - rise_ref, SYNC_STAGES + 2);
            end
            chk("bv_width", bv_d, 0);
            chk("bv_fs_overlap", frame_start, 0);
        end
        if (frame_start) begin
            n_fs++;
            chk("fs_width", fs_d, 0);
        end
        if (frame_err) begin
            n_fe++;
            chk("fe_width", fe_d, 0);
        end
        bv_d = byte_valid;
        fs_d = frame_start;
        fe_d = frame_err;
    end

    // One c4 period of 4 clk50 (2 low, 2 high); f0/data change at the fall +/-1 cycle.
    task automatic send_edge(input logic f0v, input logic dv);
        int j;
        j = jitter_on ? int'($urandom_range(2, 0)) : 1;
        for (int k = 0; k < 4; k++) begin
            if (k == j) begin
                f0 = f0v;
                data_from_dt = dv;
            end
            if (k == 0) c4 = 1'b0;
            if (k == 2) begin
                c4 = 1'b1;
                prev_rise = last_rise;
                last_rise = cyc;
            end
            @(posedge clk50); #1;
        end
    endtask

    task automatic send_bit(input logic b);
        send_edge(1'b1, b);
        send_edge(1'b1, ~b);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] val, input bit push);
        for (int i = 7; i >= 0; i--) send_bit(val[i]);
        if (push) exp_q.push_back((ch << 8) | val);
    endtask

    task automatic send_f0();
        send_edge(1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk50);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_byte_data"}, byte_data, 0);
        chk({tag, "_byte_channel"}, byte_channel, 0);
        chk({tag, "_byte_valid"}, byte_valid, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
    endtask

    logic [7:0] ra, rb;

    initial begin
        reset_in_rg = 1'b1; enable = 1'b1; c4 = 1'b0; f0 = 1'b1; data_from_dt = 1'b0;
        repeat (3) @(posedge clk50);
        #1 reset_in_rg = 1'b0;
        @(posedge clk50); #1;
        chk_idle_outputs("reset");

        // Aligned frames
        send_f0();
        send_byte(0, 8'hA5, 1);
        send_byte(1, 8'h3C, 1);
        settle();
        chk("t2_locked_first_frame", locked, 0);
        chk("t2_fc_first_frame", frame_count, 0);
        send_f0();
        settle();
        chk("t2_locked_2nd_f0", locked, 1);
        chk("t2_fc_2nd_f0", frame_count, 1);
        send_byte(0, 8'hA5, 1);
        send_byte(1, 8'h3C, 1);
        send_f0();
        settle();
        chk("t2_fc_3rd_f0", frame_count, 2);
        chk("t2_locked_3rd_f0", locked, 1);
        chk("t2_bytes_drained", exp_q.size(), 0);
        chk("t2_bv_count", n_bv, 4);

        // Early f0 after 20 data edges
        send_byte(0, 8'h5A, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_f0();
        settle();
        chk("t3_frame_err_count", n_fe, 1);
        chk("t3_locked", locked, 0);
        chk("t3_fc", frame_count, 2);
        send_byte(0, 8'h81, 1);
        send_byte(1, 8'h7E, 1);
        send_f0();
        settle();
        chk("t3_relock", locked, 1);
        chk("t3_fc_relock", frame_count, 3);

        // Missing f0: 33rd data edge
        send_byte(0, 8'h11, 1);
        send_byte(1, 8'h22, 1);
        send_edge(1'b1, 1'b1);
        settle();
        chk("t4_frame_err_count", n_fe, 2);
        chk("t4_locked", locked, 0);
        send_byte(0, 8'h33, 0);
        settle();
        chk("t4_no_bytes_in_hunt", n_bv, 9);
        send_f0();
        send_byte(0, 8'h44, 1);
        send_byte(1, 8'h55, 1);
        send_f0();
        settle();
        chk("t4_relock", locked, 1);
        chk("t4_fc", frame_count, 4);

        // Enable dropped mid-channel
        send_byte(0, 8'hC3, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        enable = 1'b0;
        @(posedge clk50); #1;
        chk("t5_locked_off", locked, 0);
        chk("t5_byte_data_held", byte_data, 8'hC3);
        chk("t5_fc_held", frame_count, 4);
        send_f0();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        settle();
        enable = 1'b1;
        send_f0();
        send_byte(0, 8'h96, 1);
        send_byte(1, 8'h69, 1);
        send_f0();
        settle();
        chk("t5_relock", locked, 1);
        chk("t5_fc_relock", frame_count, 5);
        send_byte(0, 8'h0F, 1);
        send_byte(1, 8'hF0, 1);
        send_f0();
        settle();
        chk("t5_fc_2nd", frame_count, 6);
        chk("t5_bv_count", n_bv, 16);

        // Minimum c4 period with f0/data phase jitter
        jitter_on = 1'b1;
        for (int f = 0; f < 3; f++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send_byte(0, ra, 1);
            send_byte(1, rb, 1);
            send_f0();
        end
        jitter_on = 1'b0;
        settle();
        chk("t6_fc", frame_count, 9);
        chk("t6_locked", locked, 1);
        chk("t6_bytes_drained", exp_q.size(), 0);

        // Reset mid-frame
        send_byte(0, 8'hE7, 1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        reset_in_rg = 1'b1;
        repeat (3) @(posedge clk50);
        #1 reset_in_rg = 1'b0;
        @(posedge clk50); #1;
        chk_idle_outputs("t1");
        send_byte(1, 8'h5B, 0);
        settle();
        chk("t1_no_bytes_after_reset", n_bv, 23);
        chk("t1_locked", locked, 0);
        send_f0();
        send_byte(0, 8'hB4, 1);
        settle();
        chk("t1_fc", frame_count, 0);

        chk("final_bytes_drained", exp_q.size(), 0);
        chk("final_bv_count", n_bv, 24);
        chk("final_fs_count", n_fs, 9);
        chk("final_fe_count", n_fe, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
